// File: rtl/data_memory_dma.sv
// data_memory_dma: byte-wise block copier driving the data memory manager bus.
// Each byte takes four cycles: source address latch, read, destination
// address latch, then write.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_start, in_abort   control from the control unit
//   in_src_addr/dst_addr first source/destination address
//   in_len               byte count (0 legal)
//   in_src_inc/dst_inc   1 = step address each byte, 0 = hold (port streaming)
//   out_busy, out_done   status; done is a one-cycle pulse
//   out_count            bytes written in the current transfer
//   out_mem_*            bus strobes/address/write data to the memory manager
//   in_mem_rdata         read data from the memory manager
module data_memory_dma #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_start,
  input  logic              in_abort,
  input  logic [ADDR_W-1:0] in_src_addr,
  input  logic [ADDR_W-1:0] in_dst_addr,
  input  logic [LEN_W-1:0]  in_len,
  input  logic              in_src_inc,
  input  logic              in_dst_inc,
  output logic              out_busy,
  output logic              out_done,
  output logic [LEN_W-1:0]  out_count,
  output logic [ADDR_W-1:0] out_mem_addr,
  output logic              out_mem_addr_we,
  output logic              out_mem_read_en,
  output logic              out_mem_write_en,
  output logic [DATA_W-1:0] out_mem_wdata,
  input  logic [DATA_W-1:0] in_mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SRC_ADDR,
    S_READ,
    S_DST_ADDR,
    S_WRITE,
    S_DONE
  } state_e;

  localparam logic [ADDR_W-1:0] A_ONE = 1;
  localparam logic [LEN_W-1:0]  L_ONE = 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                sinc_q, sinc_d;
  logic                dinc_q, dinc_d;
  logic                busy;

  assign busy = (state_q != S_IDLE) &&
                (state_q != S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      sinc_q  <= 1'b0;
      dinc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      sinc_q  <= sinc_d;
      dinc_q  <= dinc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    sinc_d  = sinc_q;
    dinc_d  = dinc_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_start) begin
          src_d  = in_src_addr;
          dst_d  = in_dst_addr;
          rem_d  = in_len;
          sinc_d = in_src_inc;
          dinc_d = in_dst_inc;
          cnt_d  = '0;
          state_d = (in_len == '0) ? S_DONE
                                   : S_SRC_ADDR;
        end
      end
      S_SRC_ADDR: state_d = S_READ;
      S_READ: begin
        data_d = in_mem_rdata;
        if (sinc_q) src_d = src_q + A_ONE;
        state_d = S_DST_ADDR;
      end
      S_DST_ADDR: state_d = S_WRITE;
      S_WRITE: begin
        // The write strobe is already on the bus, so the byte
        // counts even if this cycle is being aborted.
        cnt_d = cnt_q + L_ONE;
        rem_d = rem_q - L_ONE;
        if (dinc_q) dst_d = dst_q + A_ONE;
        state_d = (rem_q == L_ONE) ? S_DONE
                                   : S_SRC_ADDR;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (in_abort && busy) state_d = S_IDLE;
  end

  // Bus strobes depend on the state register only.
  always_comb begin
    out_mem_addr     = '0;
    out_mem_addr_we  = 1'b0;
    out_mem_read_en  = 1'b0;
    out_mem_write_en = 1'b0;
    out_mem_wdata    = '0;
    unique case (1'b1)
      (state_q == S_SRC_ADDR): begin
        out_mem_addr    = src_q;
        out_mem_addr_we = 1'b1;
      end
      (state_q == S_READ): begin
        out_mem_addr    = src_q;
        out_mem_read_en = 1'b1;
      end
      (state_q == S_DST_ADDR): begin
        out_mem_addr    = dst_q;
        out_mem_addr_we = 1'b1;
        out_mem_wdata   = data_q;
      end
      (state_q == S_WRITE): begin
        out_mem_addr     = dst_q;
        out_mem_write_en = 1'b1;
        out_mem_wdata    = data_q;
      end
      default: ;
    endcase
  end

  assign out_busy  = busy;
  assign out_done  = (state_q == S_DONE);
  assign out_count = cnt_q;

endmodule
